// File: rtl/display_timing_pipe.sv
// Pixel-clock video output stage.
// Generates programmable raster timing, issues (sx, sy) to a colour source
// with a fixed read latency, realigns the returned colour with the delayed
// sync/DE, blanks it, expands it to 8 bits per channel and registers it.
module display_timing_pipe #(
  parameter int CORDW       = 10,
  parameter int H_RES       = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_RES       = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit SYNC_POL    = 1'b0,
  parameter int IN_BPC      = 4,
  parameter int COLOR_LAT   = 1,
  parameter int EXPAND_MODE = 0
) (
  input  logic                  clk_pix,
  input  logic                  rst_pix,
  input  logic                  ce,
  output logic [CORDW-1:0]      sx,
  output logic [CORDW-1:0]      sy,
  output logic                  frame_start,
  input  logic [3*IN_BPC-1:0]   color_in,
  output logic [CORDW-1:0]      out_sx,
  output logic [CORDW-1:0]      out_sy,
  output logic                  out_de,
  output logic                  out_hsync,
  output logic                  out_vsync,
  output logic [7:0]            out_r,
  output logic [7:0]            out_g,
  output logic [7:0]            out_b,
  output logic [15:0]           frame_count
);

  localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

  localparam logic [CORDW-1:0] H_LAST = CORDW'(H_TOTAL - 1);
  localparam logic [CORDW-1:0] V_LAST = CORDW'(V_TOTAL - 1);
  localparam logic [CORDW-1:0] H_ACT  = CORDW'(H_RES);
  localparam logic [CORDW-1:0] V_ACT  = CORDW'(V_RES);
  localparam logic [CORDW-1:0] HS_BEG = CORDW'(H_RES + H_FP);
  localparam logic [CORDW-1:0] HS_END = CORDW'(H_RES + H_FP + H_SYNC);
  localparam logic [CORDW-1:0] VS_BEG = CORDW'(V_RES + V_FP);
  localparam logic [CORDW-1:0] VS_END = CORDW'(V_RES + V_FP + V_SYNC);

  // Tap layout: {h, v, de, hsync_active, vsync_active}; syncs are carried as
  // "active" flags so a cleared tap is always an inactive, blanked pixel.
  localparam int TW = 2 * CORDW + 3;

  // Channel widening: zero-pad the LSBs or replicate the value MSB-first.
  function automatic logic [7:0] expand(input logic [IN_BPC-1:0] c);
    logic [7:0] res;
    res = '0;
    if (EXPAND_MODE == 0) begin
      res = 8'(c) << (8 - IN_BPC);
    end else begin
      for (int i = 0; i < 8; i++) begin
        res[7-i] = c[IN_BPC-1-(i % IN_BPC)];
      end
    end
    return res;
  endfunction

  logic [CORDW-1:0] h, v;
  logic             vld_p0, hs_p0, vs_p0;
  logic [TW-1:0]    tap_p0, tap_p1;
  logic [CORDW-1:0] h_p1, v_p1;
  logic             vld_p1, hs_p1, vs_p1;
  logic [IN_BPC-1:0] r_in, g_in, b_in;

  // Stage p0: raster counters and frame counter, advancing on each enabled pixel
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      h           <= '0;
      v           <= '0;
      frame_count <= '0;
    end else if (ce) begin
      if (h == H_LAST) begin
        h <= '0;
        if (v == V_LAST) begin
          v           <= '0;
          frame_count <= frame_count + 16'd1;
        end else begin
          v <= v + 1'b1;
        end
      end else begin
        h <= h + 1'b1;
      end
    end
  end

  assign sx          = h;
  assign sy          = v;
  assign frame_start = ce && (h == '0) && (v == '0);

  assign vld_p0 = (h < H_ACT) && (v < V_ACT);
  assign hs_p0  = (h >= HS_BEG) && (h < HS_END);
  assign vs_p0  = (v >= VS_BEG) && (v < VS_END);
  assign tap_p0 = {h, v, vld_p0, hs_p0, vs_p0};

  // Stage p0 -> p1: delay line matching the colour source read latency
  generate
    if (COLOR_LAT == 0) begin : g_nodly
      assign tap_p1 = tap_p0;
    end else begin : g_dly
      logic [TW-1:0] dly [COLOR_LAT];

      // Shift the decoded timing along with the outstanding colour reads
      always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
          for (int i = 0; i < COLOR_LAT; i++) dly[i] <= '0;
        end else if (ce) begin
          dly[0] <= tap_p0;
          for (int i = 1; i < COLOR_LAT; i++) dly[i] <= dly[i-1];
        end
      end

      assign tap_p1 = dly[COLOR_LAT-1];
    end
  endgenerate

  assign {h_p1, v_p1, vld_p1, hs_p1, vs_p1} = tap_p1;

  assign r_in = color_in[3*IN_BPC-1 -: IN_BPC];
  assign g_in = color_in[2*IN_BPC-1 -: IN_BPC];
  assign b_in = color_in[IN_BPC-1:0];

  // Stage p1 -> output: sample colour with its coordinates, blank and expand
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      out_sx    <= '0;
      out_sy    <= '0;
      out_de    <= 1'b0;
      out_hsync <= ~SYNC_POL;
      out_vsync <= ~SYNC_POL;
      out_r     <= '0;
      out_g     <= '0;
      out_b     <= '0;
    end else if (ce) begin
      out_sx    <= h_p1;
      out_sy    <= v_p1;
      out_de    <= vld_p1;
      out_hsync <= hs_p1 ? SYNC_POL : ~SYNC_POL;
      out_vsync <= vs_p1 ? SYNC_POL : ~SYNC_POL;
      out_r     <= vld_p1 ? expand(r_in) : 8'h00;
      out_g     <= vld_p1 ? expand(g_in) : 8'h00;
      out_b     <= vld_p1 ? expand(b_in) : 8'h00;
    end
  end

endmodule

// File: tb/tb_display_timing_pipe.sv
// Bench for display_timing_pipe: four instances with different rasters,
// latencies and expansion modes, checked every cycle against a closed-form
// model driven by the count of enabled cycles since reset.
module tb_display_timing_pipe;

  logic clk_pix = 1'b0;
  always #5 clk_pix = ~clk_pix;

  int checks   = 0;
  int failures = 0;

  // A: 20x11 raster, latency 3, 4-bit zero-pad, active-low syncs, random ce
  logic        rstA, ceA, fsA, deA, hsA, vsA;
  logic [9:0]  sxA, syA, oxA, oyA;
  logic [11:0] colA;
  logic [7:0]  rA, gA, bA;
  logic [15:0] fcA;
  // B: 4x2 raster, latency 0, 3-bit replicate, active-high syncs
  logic        rstB, ceB, fsB, deB, hsB, vsB;
  logic [9:0]  sxB, syB, oxB, oyB;
  logic [8:0]  colB;
  logic [7:0]  rB, gB, bB;
  logic [15:0] fcB;
  // C: 1x1 raster (one frame per pixel), latency 1, 4-bit replicate
  logic        rstC, ceC, fsC, deC, hsC, vsC;
  logic [9:0]  sxC, syC, oxC, oyC;
  logic [11:0] colC;
  logic [7:0]  rC, gC, bC;
  logic [15:0] fcC;
  // D: default 640x480 timing
  logic        rstD, ceD, fsD, deD, hsD, vsD;
  logic [9:0]  sxD, syD, oxD, oyD;
  logic [11:0] colD;
  logic [7:0]  rD, gD, bD;
  logic [15:0] fcD;

  display_timing_pipe #(.CORDW(10), .H_RES(12), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_RES(6), .V_FP(1), .V_SYNC(2), .V_BP(2), .SYNC_POL(1'b0), .IN_BPC(4),
    .COLOR_LAT(3), .EXPAND_MODE(0)) dut_a (
    .clk_pix(clk_pix), .rst_pix(rstA), .ce(ceA), .sx(sxA), .sy(syA),
    .frame_start(fsA), .color_in(colA), .out_sx(oxA), .out_sy(oyA),
    .out_de(deA), .out_hsync(hsA), .out_vsync(vsA), .out_r(rA), .out_g(gA),
    .out_b(bA), .frame_count(fcA));

  display_timing_pipe #(.CORDW(10), .H_RES(2), .H_FP(1), .H_SYNC(1), .H_BP(0),
    .V_RES(1), .V_FP(0), .V_SYNC(1), .V_BP(0), .SYNC_POL(1'b1), .IN_BPC(3),
    .COLOR_LAT(0), .EXPAND_MODE(1)) dut_b (
    .clk_pix(clk_pix), .rst_pix(rstB), .ce(ceB), .sx(sxB), .sy(syB),
    .frame_start(fsB), .color_in(colB), .out_sx(oxB), .out_sy(oyB),
    .out_de(deB), .out_hsync(hsB), .out_vsync(vsB), .out_r(rB), .out_g(gB),
    .out_b(bB), .frame_count(fcB));

  display_timing_pipe #(.CORDW(10), .H_RES(1), .H_FP(0), .H_SYNC(0), .H_BP(0),
    .V_RES(1), .V_FP(0), .V_SYNC(0), .V_BP(0), .SYNC_POL(1'b0), .IN_BPC(4),
    .COLOR_LAT(1), .EXPAND_MODE(1)) dut_c (
    .clk_pix(clk_pix), .rst_pix(rstC), .ce(ceC), .sx(sxC), .sy(syC),
    .frame_start(fsC), .color_in(colC), .out_sx(oxC), .out_sy(oyC),
    .out_de(deC), .out_hsync(hsC), .out_vsync(vsC), .out_r(rC), .out_g(gC),
    .out_b(bC), .frame_count(fcC));

  display_timing_pipe dut_d (
    .clk_pix(clk_pix), .rst_pix(rstD), .ce(ceD), .sx(sxD), .sy(syD),
    .frame_start(fsD), .color_in(colD), .out_sx(oxD), .out_sy(oyD),
    .out_de(deD), .out_hsync(hsD), .out_vsync(vsD), .out_r(rD), .out_g(gD),
    .out_b(bD), .frame_count(fcD));

  // Colour sources
  function automatic logic [8:0] tab_b(input logic [1:0] i);
    case (i)
      2'd0:    return 9'b101_010_111;
      2'd1:    return 9'b001_100_011;
      2'd2:    return 9'b110_000_101;
      default: return 9'b011_111_001;
    endcase
  endfunction

  function automatic logic [7:0] rep3(input logic [2:0] c);
    logic [8:0] w;
    w = {c, c, c};
    return w[8:1];
  endfunction

  logic [2:0][11:0] pipeA;
  always @(posedge clk_pix) begin
    if (ceA) pipeA <= {pipeA[1:0], {sxA[3:0], syA[3:0], 4'h5}};
    if (ceD) colD  <= {sxD[3:0], syD[3:0], 4'h5};
  end
  assign colA = pipeA[2];
  assign colB = tab_b(sxB[1:0]);
  assign colC = 12'hA5F;

  // Enabled-cycle counts since the last reset edge
  int nA = 0, nB = 0, nC = 0, nD = 0;
  bit armA = 1'b0, armB = 1'b0, armC = 1'b0, armD = 1'b0;
  always @(posedge clk_pix) begin
    nA <= rstA ? 0 : (ceA ? nA + 1 : nA);
    nB <= rstB ? 0 : (ceB ? nB + 1 : nB);
    nC <= rstC ? 0 : (ceC ? nC + 1 : nC);
    nD <= rstD ? 0 : (ceD ? nD + 1 : nD);
    armA <= armA | rstA;
    armB <= armB | rstB;
    armC <= armC | rstC;
    armD <= armD | rstD;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", tag, act, exp);
    end
  endtask

  // Expected outputs from the raster rules: after n enabled cycles the issue
  // side shows pixel index n, the output side pixel index n-(lat+1).
  task automatic model_chk(input string t, input int n, input int ht, input int vt,
                           input int hr, input int hfp, input int hs, input int vr,
                           input int vfp, input int vs, input bit pol, input int lat,
                           input int kind, input logic ce_now,
                           input logic [9:0] a_sx, input logic [9:0] a_sy,
                           input logic a_fs, input logic [15:0] a_fc,
                           input logic [9:0] a_ox, input logic [9:0] a_oy,
                           input logic a_de, input logic a_hs, input logic a_vs,
                           input logic [7:0] a_r, input logic [7:0] a_g,
                           input logic [7:0] a_b);
    int m, oh, ov;
    bit ok, ode, ohs, ovs;
    logic [7:0] er, eg, eb;
    logic [8:0] cw;
    chk({t, "_sx"}, 32'(a_sx), n % ht);
    chk({t, "_sy"}, 32'(a_sy), (n / ht) % vt);
    chk({t, "_frame_start"}, 32'(a_fs), 32'(ce_now && (n % (ht * vt) == 0)));
    chk({t, "_frame_count"}, 32'(a_fc), (n / (ht * vt)) % 65536);
    m   = n - lat - 1;
    ok  = (m >= 0);
    oh  = ok ? m % ht : 0;
    ov  = ok ? (m / ht) % vt : 0;
    ode = ok && oh < hr && ov < vr;
    ohs = ok && oh >= hr + hfp && oh < hr + hfp + hs;
    ovs = ok && ov >= vr + vfp && ov < vr + vfp + vs;
    er = 8'h00; eg = 8'h00; eb = 8'h00;
    if (ode) begin
      case (kind)
        0: begin
          er = {4'(oh), 4'h0};
          eg = {4'(ov), 4'h0};
          eb = 8'h50;
        end
        1: begin
          cw = tab_b(2'(oh));
          er = rep3(cw[8:6]);
          eg = rep3(cw[5:3]);
          eb = rep3(cw[2:0]);
        end
        default: begin
          er = 8'hAA;
          eg = 8'h55;
          eb = 8'hFF;
        end
      endcase
    end
    chk({t, "_out_sx"}, 32'(a_ox), oh);
    chk({t, "_out_sy"}, 32'(a_oy), ov);
    chk({t, "_out_de"}, 32'(a_de), 32'(ode));
    chk({t, "_out_hsync"}, 32'(a_hs), 32'(ohs ? pol : !pol));
    chk({t, "_out_vsync"}, 32'(a_vs), 32'(ovs ? pol : !pol));
    chk({t, "_out_r"}, 32'(a_r), 32'(er));
    chk({t, "_out_g"}, 32'(a_g), 32'(eg));
    chk({t, "_out_b"}, 32'(a_b), 32'(eb));
  endtask

  // Single compare process: model every cycle plus hand-computed pins
  always @(negedge clk_pix) begin
    if (armA) begin
      model_chk("A", nA, 20, 11, 12, 2, 3, 6, 1, 2, 1'b0, 3, 0, ceA,
                sxA, syA, fsA, fcA, oxA, oyA, deA, hsA, vsA, rA, gA, bA);
      if (nA == 3)  chk("A_pin_de_flush", 32'(deA), 32'd0);
      if (nA == 14) chk("A_pin_zero_pad_A", 32'(rA), 32'h00A0);
      if (nA == 25) chk("A_pin_g_row1", 32'(gA), 32'h0010);
      if (nA == 17) chk("A_pin_hsync_before", 32'(hsA), 32'd1);
      if (nA == 18) chk("A_pin_hsync_start", 32'(hsA), 32'd0);
    end
    if (armB) begin
      model_chk("B", nB, 4, 2, 2, 1, 1, 1, 0, 1, 1'b1, 0, 1, ceB,
                sxB, syB, fsB, fcB, oxB, oyB, deB, hsB, vsB, rB, gB, bB);
      if (nB == 1) chk("B_pin_rep_101", 32'(rB), 32'h00B6);
      if (nB == 1) chk("B_pin_rep_010", 32'(gB), 32'h0049);
      if (nB == 2) chk("B_pin_rep_100", 32'(gB), 32'h0092);
      if (nB == 3) chk("B_pin_blank", 32'(rB), 32'd0);
      if (nB == 5) chk("B_pin_vsync_high", 32'(vsB), 32'd1);
    end
    if (armC) begin
      model_chk("C", nC, 1, 1, 1, 0, 0, 1, 0, 0, 1'b0, 1, 2, ceC,
                sxC, syC, fsC, fcC, oxC, oyC, deC, hsC, vsC, rC, gC, bC);
      if (nC == 2)     chk("C_pin_rep_A", 32'(rC), 32'h00AA);
      if (nC == 65535) chk("C_pin_fc_max", 32'(fcC), 32'h0000FFFF);
      if (nC == 65536) chk("C_pin_fc_wrap", 32'(fcC), 32'd0);
    end
    if (armD) begin
      model_chk("D", nD, 800, 525, 640, 16, 96, 480, 10, 2, 1'b0, 1, 0, ceD,
                sxD, syD, fsD, fcD, oxD, oyD, deD, hsD, vsD, rD, gD, bD);
      if (nD == 641) chk("D_pin_de_last", 32'(deD), 32'd1);
      if (nD == 642) chk("D_pin_de_fp", 32'(deD), 32'd0);
      if (nD == 657) chk("D_pin_hsync_655", 32'(hsD), 32'd1);
      if (nD == 658) chk("D_pin_hsync_656", 32'(hsD), 32'd0);
      if (nD == 658) chk("D_pin_out_sx_656", 32'(oxD), 32'd656);
    end
  end

  initial begin
    rstA = 1'b1; rstB = 1'b1; rstC = 1'b1; rstD = 1'b1;
    ceA  = 1'b1; ceB  = 1'b1; ceC  = 1'b1; ceD  = 1'b1;
    repeat (3) @(posedge clk_pix);
    #1;
    rstA = 1'b0; rstB = 1'b0; rstC = 1'b0; rstD = 1'b0;
    for (int cyc = 0; cyc < 65600; cyc++) begin
      @(posedge clk_pix);
      #1;
      // Mid-frame resets held three cycles with ce high
      rstA = (cyc >= 300 && cyc < 303);
      rstB = (cyc >= 100 && cyc < 103);
      ceA  = rstA ? 1'b1 : ($urandom_range(0, 3) != 0);
      ceB  = rstB ? 1'b1 : ((cyc % 5) != 3);
    end
    @(negedge clk_pix);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
